// File: rtl/csr_counter_array.sv
// csr_counter_array: machine counter CSR block (mcycle, minstret, mhpmcounterN)
// with inhibit, overflow status/enable and an overflow interrupt.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_csr_ex .. rs1_sel     pipeline CSR access (address, funct3, operands)
//   stall                     blocks pipeline writes
//   retire, hpm_event         counter increment strobes
//   csr_hit, csr_rd_data      decode hit and combinational read data
//   csr_ro_err                pipeline write attempt to a read-only alias
//   cnt_ovf_irq               registered overflow interrupt
//   csr_*_mon                 monitor read/write port; csr_rdata_mon mirrors csr_rd_data
module csr_counter_array #(
    parameter int unsigned NUM_HPM   = 4,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cmd_csr_ex,
    input  logic [11:0]                              csr_ofs_ex,
    input  logic [2:0]                               csr_op2_ex,
    input  logic [4:0]                               csr_uimm_ex,
    input  logic [31:0]                              rs1_sel,
    input  logic                                     stall,
    input  logic                                     retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    output logic                                     csr_hit,
    output logic [31:0]                              csr_rd_data,
    output logic                                     csr_ro_err,
    output logic                                     cnt_ovf_irq,
    input  logic                                     csr_radr_en_mon,
    input  logic [11:0]                              csr_radr_mon,
    input  logic                                     csr_we_mon,
    input  logic [11:0]                              csr_wadr_mon,
    input  logic [31:0]                              csr_wdata_mon,
    output logic [31:0]                              csr_rdata_mon
);

    localparam int unsigned NCNT = NUM_HPM + 3;
    localparam int unsigned HW   = CNT_WIDTH - 32;

    localparam logic [11:0] ADDR_INH   = 12'h320;
    localparam logic [11:0] ADDR_OVF   = 12'h7C0;
    localparam logic [11:0] ADDR_OVFEN = 12'h7C1;

    // Implemented counter slots: 0 (mcycle), 2 (minstret), 3..NCNT-1 (hpm)
    localparam logic [63:0] HPM_BITS  = ((64'd1 << NUM_HPM) - 64'd1) << 3;
    localparam logic [31:0] HPM_MASK  = HPM_BITS[31:0];
    localparam logic [31:0] IMPL_MASK = HPM_MASK | 32'h0000_0005;

    typedef logic [31:0][CNT_WIDTH-1:0] cnt_arr_t;

    function automatic logic idx_valid(input logic [4:0] idx);
        return (idx == 5'd0) || (idx == 5'd2) ||
               ((idx >= 5'd3) && ({27'd0, idx} < NCNT));
    endfunction

    // Counter address in region 0xB (read/write) or 0xC (read-only alias)
    function automatic logic is_cnt(input logic [11:0] a, input logic [3:0] region);
        return (a[11:8] == region) && (a[6:5] == 2'b00) && idx_valid(a[4:0]);
    endfunction

    function automatic logic writable(input logic [11:0] a);
        return is_cnt(a, 4'hB) || (a == ADDR_INH) || (a == ADDR_OVF) || (a == ADDR_OVFEN);
    endfunction

    function automatic logic implemented(input logic [11:0] a);
        return writable(a) || is_cnt(a, 4'hC);
    endfunction

    function automatic logic [31:0] csr_read(input logic [11:0] a, input cnt_arr_t c,
                                             input logic [31:0] inh, input logic [31:0] ovf,
                                             input logic [31:0] ovfen);
        logic [CNT_WIDTH-1:0] sel;
        logic [31:0]          r;
        sel = c[a[4:0]];
        r   = '0;
        if (a == ADDR_INH) begin
            r = inh;
        end else if (a == ADDR_OVF) begin
            r = ovf;
        end else if (a == ADDR_OVFEN) begin
            r = ovfen;
        end else if (is_cnt(a, 4'hB) || is_cnt(a, 4'hC)) begin
            r = a[7] ? 32'(sel[CNT_WIDTH-1:32]) : sel[31:0];
        end
        return r;
    endfunction

    logic [31:0] inh_q, ovf_q, ovfen_q;
    logic [31:0] inh_d, ovf_d, ovfen_d;
    logic        irq_d;
    cnt_arr_t    cnt_all;
    logic [31:0] ovf_set;

    logic [11:0] dec_addr;
    logic [31:0] pipe_operand, pipe_rd, pipe_val;
    logic        pipe_try, pipe_we, mon_we;
    logic        wr_en, wr_cnt;
    logic [11:0] wr_addr;
    logic [31:0] wr_val;
    logic [31:0] wr_lo_hit, wr_hi_hit, inc;
    logic [31:0] ovf_base;

    // Read decode shared by the pipeline and monitor read ports
    always_comb begin
        dec_addr = csr_ofs_ex;
        if (csr_radr_en_mon) begin
            dec_addr = csr_radr_mon;
        end else if (csr_we_mon) begin
            dec_addr = csr_wadr_mon;
        end
        csr_hit       = implemented(dec_addr);
        csr_rd_data   = csr_read(dec_addr, cnt_all, inh_q, ovf_q, ovfen_q);
        csr_rdata_mon = csr_rd_data;
    end

    // Write arbitration: pipeline wins, monitor writes only in idle pipeline cycles
    always_comb begin
        pipe_operand = csr_op2_ex[2] ? {27'd0, csr_uimm_ex} : rs1_sel;
        pipe_rd      = csr_read(csr_ofs_ex, cnt_all, inh_q, ovf_q, ovfen_q);
        pipe_val     = pipe_operand;
        case (csr_op2_ex[1:0])
            2'b10:   pipe_val = pipe_operand | pipe_rd;
            2'b11:   pipe_val = ~pipe_operand & pipe_rd;
            default: pipe_val = pipe_operand;
        endcase
        pipe_try   = cmd_csr_ex && !stall && (csr_op2_ex[1:0] != 2'b00);
        pipe_we    = pipe_try && writable(csr_ofs_ex);
        csr_ro_err = pipe_try && is_cnt(csr_ofs_ex, 4'hC);
        mon_we     = csr_we_mon && !pipe_we && writable(csr_wadr_mon);

        wr_en   = pipe_we || mon_we;
        wr_addr = pipe_we ? csr_ofs_ex : csr_wadr_mon;
        wr_val  = pipe_we ? pipe_val : csr_wdata_mon;
        wr_cnt  = wr_en && is_cnt(wr_addr, 4'hB);

        wr_lo_hit = '0;
        wr_hi_hit = '0;
        if (wr_cnt) begin
            if (wr_addr[7]) begin
                wr_hi_hit[wr_addr[4:0]] = 1'b1;
            end else begin
                wr_lo_hit[wr_addr[4:0]] = 1'b1;
            end
        end

        inc = (((32'(hpm_event) << 3) & HPM_MASK) | {29'd0, retire, 1'b0, 1'b1}) & ~inh_q;
    end

    // Per-slot counters; unimplemented slots read as constant zero
    for (genvar k = 0; k < 32; k++) begin : g_cnt
        if ((k == 0) || (k == 2) || ((k >= 3) && (k < int'(NCNT)))) begin : g_impl
            logic [CNT_WIDTH-1:0] q, d;
            logic                 wrap;

            // A write to either half suppresses that cycle's increment
            always_comb begin
                d    = q;
                wrap = 1'b0;
                if (wr_lo_hit[k]) begin
                    d[31:0] = wr_val;
                end else if (wr_hi_hit[k]) begin
                    d[CNT_WIDTH-1:32] = wr_val[HW-1:0];
                end else if (inc[k]) begin
                    d    = q + CNT_WIDTH'(1);
                    wrap = &q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else begin
                    q <= d;
                end
            end

            assign cnt_all[k] = q;
            assign ovf_set[k] = wrap;
        end else begin : g_none
            assign cnt_all[k] = '0;
            assign ovf_set[k] = 1'b0;
        end
    end

    // Control registers; overflow set beats a same-cycle clear
    always_comb begin
        inh_d    = inh_q;
        ovfen_d  = ovfen_q;
        ovf_base = ovf_q;
        if (wr_en && (wr_addr == ADDR_INH)) begin
            inh_d = wr_val & IMPL_MASK;
        end
        if (wr_en && (wr_addr == ADDR_OVFEN)) begin
            ovfen_d = wr_val & IMPL_MASK;
        end
        if (wr_en && (wr_addr == ADDR_OVF)) begin
            ovf_base = ovf_q & ~wr_val;
        end
        ovf_d = (ovf_base | ovf_set) & IMPL_MASK;
        irq_d = |(ovf_d & ovfen_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_q       <= '0;
            ovf_q       <= '0;
            ovfen_q     <= '0;
            cnt_ovf_irq <= 1'b0;
        end else begin
            inh_q       <= inh_d;
            ovf_q       <= ovf_d;
            ovfen_q     <= ovfen_d;
            cnt_ovf_irq <= irq_d;
        end
    end

endmodule

// File: doc/csr_counter_array.md
CSR_COUNTER_ARRAY -- requirements
Module: csr_counter_array

Interface
REQ-001 The block SHALL have these parameters: NUM_HPM, default 4, number of mhpmcounter3..(3+NUM_HPM-1), legal 0..29; CNT_WIDTH, default 64, width of every counter, legal 33..64.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_csr_ex  in  1  CSR instruction in EX
- csr_ofs_ex  in  12  CSR address
- csr_op2_ex  in  3  funct3; bit2 selects immediate; [1:0] 01=rw, 10=rs, 11=rc
- csr_uimm_ex  in  5  zero-extended immediate operand
- rs1_sel  in  32  register operand
- stall  in  1  pipeline stall; blocks pipeline writes
- retire  in  1  one instruction retired this cycle
- hpm_event  in  max(NUM_HPM,1)  per-counter increment strobes
- csr_hit  out  1  csr_ofs_ex decodes to an implemented register of this block
- csr_rd_data  out  32  combinational read data
- csr_ro_err  out  1  write attempt to a read-only alias
- cnt_ovf_irq  out  1  counter overflow interrupt request
- csr_radr_en_mon  in  1  monitor read enable
- csr_radr_mon  in  12  monitor read address
- csr_we_mon  in  1  monitor write enable
- csr_wadr_mon  in  12  monitor write address
- csr_wdata_mon  in  32  monitor write data
- csr_rdata_mon  out  32  monitor read data

Function
REQ-004 The address map SHALL be:
- mcycle 0xB00/0xB80 (lo/hi)
- minstret 0xB02/0xB82
- mhpmcounter(3+i) 0xB03+i/0xB83+i
- mcountinhibit 0x320
- mcntovf 0x7C0
- mcntovfen 0x7C1
- read-only aliases 0xC00/0xC02/0xC03+i (lo) and 0xC80/0xC82/0xC83+i (hi)
REQ-005 The decode address SHALL be csr_radr_mon if csr_radr_en_mon, else csr_wadr_mon if csr_we_mon, else csr_ofs_ex; csr_rd_data and csr_rdata_mon SHALL both carry the same selected data.
REQ-006 Lo reads SHALL return counter[31:0]; hi reads SHALL return counter[CNT_WIDTH-1:32] zero-extended to 32 bits; unimplemented addresses, including hpm indices >= NUM_HPM, SHALL read 0 with csr_hit=0.
REQ-007 The write value SHALL be: rw = operand; rs = operand | current read data; rc = ~operand & current read data. The operand SHALL be {27'd0,csr_uimm_ex} when bit2 is set, else rs1_sel.
REQ-008 A pipeline write SHALL occur when cmd_csr_ex & ~stall & op!=00 & the address is writable.
REQ-009 A monitor write SHALL occur when csr_we_mon and no pipeline write occurs that cycle.
REQ-010 A lo write SHALL replace bits [31:0] only; a hi write SHALL replace bits [CNT_WIDTH-1:32] only, with excess data bits discarded.
REQ-011 Counter increments:
- mcycle SHALL increment by 1 every cycle when inhibit[0]=0.
- minstret SHALL increment when retire & ~inhibit[2].
- hpm i SHALL increment when hpm_event[i] & ~inhibit[3+i].
REQ-012 A write to a counter in the same cycle as its increment SHALL win: the written half takes the write data, the other half holds, and there is no increment that cycle.
REQ-013 An increment of a counter holding all ones SHALL wrap it to 0 and set mcntovf[idx] on the same edge; idx = 0 for mcycle, 2 for minstret, 3+i for hpm i.
REQ-014 mcountinhibit, mcntovf and mcntovfen SHALL implement only bits 0, 2 and 3..3+NUM_HPM-1; all other bits, including bit 1, SHALL read 0 and ignore writes.
REQ-015 mcntovf SHALL be write-1-to-clear for rw writes from both pipeline and monitor; rs and rc writes SHALL also clear only the bits that are 1 in the computed write value. An overflow set in the same cycle SHALL win over a clear.
REQ-016 cnt_ovf_irq SHALL be registered: next value = |(mcntovf_next & mcntovfen_next), i.e. one cycle after the overflow edge.
REQ-017 csr_ro_err SHALL be combinational: cmd_csr_ex & ~stall & op!=00 & the address is a 0xCxx alias. The write SHALL be dropped, and the alias SHALL still read normally.

Reset
REQ-018 When rst=1, all counters, mcountinhibit, mcntovf, mcntovfen and cnt_ovf_irq SHALL be 0 immediately, regardless of clk.
REQ-019 Reset asserted mid-count or mid-write SHALL abandon the operation with no partial update after release; counting SHALL resume on the first clk edge after rst falls.

Verification
REQ-020 Release reset, run 10 cycles idle -> mcycle reads 10 at 0xB00 and 0xC00, and minstret reads 0.
REQ-021 Write 0xFFFFFFFF to 0xB00 via csrrw, then increment -> 0xB00 reads 0, 0xB80 reads 1 (carry across halves).
REQ-022 NUM_HPM=4: preload hpm3 to all ones, set mcntovfen=0x8, pulse hpm_event[0] -> hpm3=0, mcntovf=0x8, cnt_ovf_irq=1 one cycle later; write 0x8 to 0x7C0 -> irq clears on the next cycle.
REQ-023 Set mcountinhibit=0x5, pulse retire 3 times -> mcycle and minstret are frozen; clear the inhibit -> both resume.
REQ-024 csrrw to 0xC02 -> csr_ro_err=1 and minstret is unchanged; csrrw to 0xB02 with stall=1 -> no write occurs.
REQ-025 Pipeline write and monitor write to 0xB00 in the same cycle -> the pipeline value is taken, and mcycle does not increment that cycle.
